pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage; successor to the fixed 32-bit PC register. It adds configurable width, reset vector and instruction size. It also adds a stall hold, trap entry with priority over branch redirect, misaligned-target detection, and an optional direct-mapped branch target buffer (BTB) that predicts the next PC. It sits between the fetch address port and the execute-stage branch/trap resolution logic.

## Interface
- XLEN, 32, PC width in bits
- RESET_VEC, 0, PC value held during and immediately after reset
- INST_BYTES, 4, sequential increment; power of two, >=2
- BTB_DEPTH, 16, BTB entries; power of two, >=2 (used only with PC_BTB_EN)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold current PC
- redirect  in  1  branch/jump resolved; load redirect_addr
- redirect_addr  in  XLEN  redirect target
- trap  in  1  enter trap handler
- trap_vec  in  XLEN  trap target; low log2(INST_BYTES) bits forced to 0 on load
- upd_valid  in  1  BTB training strobe from execute
- upd_pc  in  XLEN  PC of resolved branch
- upd_target  in  XLEN  resolved target
- upd_taken  in  1  branch outcome
- pc  out  XLEN  current fetch address (registered)
- pc_plus  out  XLEN  pc + INST_BYTES (combinational, modulo 2^XLEN)
- pc_valid  out  1  pc is a valid fetch address
- pred_taken  out  1  BTB hit on current pc; next pc is predicted target
- misaligned  out  1  one-cycle pulse: last redirect target was misaligned and was rejected

## Operation
- FSM with two states:
  - BOOT: entered on reset. pc=RESET_VEC, pc_valid=0. Moves to RUN on the first clk edge after rst_n deasserts. No input is honoured in BOOT.
  - RUN: pc_valid=1. Stays in RUN until reset.
- Next-PC priority in RUN, highest first:
  - trap: pc <= trap_vec & ~(INST_BYTES-1).
  - redirect with aligned redirect_addr: pc <= redirect_addr.
  - redirect with misaligned redirect_addr (any low log2(INST_BYTES) bit set): pc holds; misaligned=1 for the next cycle.
  - stall: pc holds.
  - pred_taken: pc <= BTB target.
  - Otherwise pc <= pc_plus.
- trap and redirect both override stall.
- Wrap-around: pc=2^XLEN-INST_BYTES gives pc_plus=0 and next pc 0. No flag is raised.
- BTB (with PC_BTB_EN):
  - Direct-mapped. index = pc[log2(INST_BYTES) +: log2(BTB_DEPTH)]. tag = all higher pc bits.
  - Each entry holds valid, tag and target.
  - Lookup is combinational on pc. pred_taken = valid & tag match.
  - Training on upd_valid:
    - upd_taken=1: write valid=1, tag and target at upd_pc's index.
    - upd_taken=0: clear valid at that index, only if its tag matches.
  - A same-cycle lookup and write to one index: the lookup sees the old contents.
- Reset values: pc=RESET_VEC, pc_valid=0, pred_taken=0, misaligned=0, all BTB valid bits 0.

## Timing
- Single-cycle: inputs sampled at edge N take effect in pc after edge N.
- Redirect or trap asserted in cycle N: pc equals the target in cycle N+1.
- misaligned is asserted in cycle N+1 for exactly one cycle per rejected redirect.
- BTB update at edge N is visible to lookups from cycle N+1.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous), without waiting for clk. After deassertion, one BOOT cycle precedes pc_valid=1.

## Configuration
- PC_BTB_EN defined: BTB storage, lookup and training are built. pred_taken is live.
- PC_BTB_EN undefined: no BTB storage is built. pred_taken is tied 0. upd_* inputs are ignored. Next PC is pc_plus unless trap, redirect or stall applies.

## Test plan
- Reset with XLEN=32, RESET_VEC=0x1000: during reset pc=0x1000, pc_valid=0. First edge after release: pc=0x1000, pc_valid=1. Next edges: 0x1004, 0x1008.
- stall=1 for 3 cycles at pc=0x2000: pc stays 0x2000. Release: 0x2004.
- Same cycle stall=1, redirect=1 (0x3000), trap=1 (trap_vec=0x80): next pc=0x80. Redirect alone with stall: next pc=0x3000.
- redirect_addr=0x3002: pc holds, misaligned=1 for exactly one cycle. trap_vec=0x83: pc=0x80.
- pc=0xFFFFFFFC, no control inputs: next pc=0x00000000, pc_plus of 0xFFFFFFFC reads 0.
- PC_BTB_EN: train upd_pc=0x100, target 0x400, taken. Run to pc=0x100: pred_taken=1, next pc=0x400. Train not-taken: no prediction. Aliasing pc 0x140 with DEPTH=16 (tag mismatch): no prediction.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: BOOT/RUN control, trap/redirect/stall priority,
// misaligned-redirect rejection and an optional direct-mapped BTB enabled by `define PC_BTB_EN.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              INST_BYTES = 4,
  parameter int              BTB_DEPTH  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            pred_taken,
  output logic            misaligned
);

  localparam int OFF_W = $clog2(INST_BYTES);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic [XLEN-1:0] align_down(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] res;
    res = addr;
    res[OFF_W-1:0] = '0;
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |addr[OFF_W-1:0];
  endfunction

  logic [0:0]      state;
  logic            run;
  logic [XLEN-1:0] pc_next;
  logic            mis_next;
  logic [XLEN-1:0] pred_target;

  assign run      = (state == RUN);
  assign pc_valid = run;
  assign pc_plus  = pc + XLEN'(INST_BYTES);

`ifdef PC_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - OFF_W - IDX_W;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      btb_target [BTB_DEPTH];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             train_en;
  logic             unused_upd_lo;

  assign look_idx = pc[OFF_W +: IDX_W];
  assign look_tag = pc[XLEN-1 -: TAG_W];
  assign upd_idx  = upd_pc[OFF_W +: IDX_W];
  assign upd_tag  = upd_pc[XLEN-1 -: TAG_W];
  assign train_en = run && upd_valid;
  assign unused_upd_lo = ^upd_pc[OFF_W-1:0];

  // Lookup is purely combinational on the current pc, so a same-cycle write is seen next cycle.
  assign pred_taken  = run && btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign pred_target = btb_target[look_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid <= '0;
    end else if (train_en) begin
      if (upd_taken) begin
        btb_valid[upd_idx] <= 1'b1;
      end else if (btb_tag[upd_idx] == upd_tag) begin
        btb_valid[upd_idx] <= 1'b0;
      end
    end
  end

  // Tag and target are qualified by btb_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (train_en && upd_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
    end
  end
`else
  logic unused_upd;

  assign pred_taken  = 1'b0;
  assign pred_target = '0;
  assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken, BTB_DEPTH[0]};
`endif

  always_comb begin
    pc_next  = pc;
    mis_next = 1'b0;
    if (run) begin
      if (trap) begin
        pc_next = align_down(trap_vec);
      end else if (redirect) begin
        if (is_misaligned(redirect_addr)) begin
          mis_next = 1'b1;
        end else begin
          pc_next = redirect_addr;
        end
      end else if (!stall) begin
        if (pred_taken) begin
          pc_next = pred_target;
        end else begin
          pc_next = pc_plus;
        end
      end
    end
  end

  // BOOT lasts exactly one edge after reset release; pc stays at RESET_VEC across it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      misaligned <= 1'b0;
    end else begin
      state      <= RUN;
      pc         <= pc_next;
      misaligned <= mis_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen (XLEN=32, RESET_VEC=0x1000): vector table plus reset and BTB sequences.
// BTB expectations switch on `define PC_BTB_EN to match the build.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, trap;
  logic [31:0] redirect_addr, trap_vec;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] pc, pc_plus;
  logic        pc_valid, pred_taken, misaligned;

  pc_gen #(
    .XLEN(32), .RESET_VEC(32'h0000_1000), .INST_BYTES(4), .BTB_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .trap(trap), .trap_vec(trap_vec),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid),
    .pred_taken(pred_taken), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        mis;
    logic        pred;
  } exp_t;

  typedef struct packed {
    logic        stall;
    logic        redirect;
    logic [31:0] raddr;
    logic        trap;
    logic [31:0] tvec;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef PC_BTB_EN
  localparam logic BTB = 1'b1;
`else
  localparam logic BTB = 1'b0;
`endif

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic check_now(input string tag, input exp_t e);
    cmp({tag, " pc"}, pc, e.pc);
    cmp({tag, " pc_plus"}, pc_plus, e.pc + 32'd4);
    cmp({tag, " pc_valid"}, {31'd0, pc_valid}, {31'd0, e.vld});
    cmp({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
    cmp({tag, " pred_taken"}, {31'd0, pred_taken}, {31'd0, e.pred});
  endtask

  task automatic clear_in();
    stall = 0; redirect = 0; trap = 0; redirect_addr = 0; trap_vec = 0;
    upd_valid = 0; upd_taken = 0; upd_pc = 0; upd_target = 0;
  endtask

  // Expectation is queued when the stimulus is driven, popped after the edge it applies to.
  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check_now(tag, got);
    end
  endtask

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{stall:0, redirect:1, raddr:32'h2000, trap:0, tvec:0, exp_pc:32'h2000, exp_mis:0};
    vecs[1]  = '{stall:1, redirect:0, raddr:0, trap:0, tvec:0, exp_pc:32'h2000, exp_mis:0};
    vecs[2]  = '{stall:1, redirect:0, raddr:0, trap:0, tvec:0, exp_pc:32'h2000, exp_mis:0};
    vecs[3]  = '{stall:1, redirect:0, raddr:0, trap:0, tvec:0, exp_pc:32'h2000, exp_mis:0};
    vecs[4]  = '{stall:0, redirect:0, raddr:0, trap:0, tvec:0, exp_pc:32'h2004, exp_mis:0};
    vecs[5]  = '{stall:1, redirect:1, raddr:32'h3000, trap:1, tvec:32'h80, exp_pc:32'h80, exp_mis:0};
    vecs[6]  = '{stall:1, redirect:1, raddr:32'h3000, trap:0, tvec:0, exp_pc:32'h3000, exp_mis:0};
    vecs[7]  = '{stall:0, redirect:1, raddr:32'h3002, trap:0, tvec:0, exp_pc:32'h3000, exp_mis:1};
    vecs[8]  = '{stall:0, redirect:0, raddr:0, trap:0, tvec:0, exp_pc:32'h3004, exp_mis:0};
    vecs[9]  = '{stall:0, redirect:0, raddr:0, trap:1, tvec:32'h83, exp_pc:32'h80, exp_mis:0};
    vecs[10] = '{stall:0, redirect:1, raddr:32'hFFFF_FFFC, trap:0, tvec:0, exp_pc:32'hFFFF_FFFC, exp_mis:0};
    vecs[11] = '{stall:0, redirect:0, raddr:0, trap:0, tvec:0, exp_pc:32'h0, exp_mis:0};
    vecs[12] = '{stall:0, redirect:1, raddr:32'h3002, trap:1, tvec:32'h200, exp_pc:32'h200, exp_mis:0};
    vecs[13] = '{stall:1, redirect:1, raddr:32'h5006, trap:0, tvec:0, exp_pc:32'h200, exp_mis:1};
    vecs[14] = '{stall:0, redirect:1, raddr:32'h500A, trap:0, tvec:0, exp_pc:32'h200, exp_mis:1};
    vecs[15] = '{stall:0, redirect:0, raddr:0, trap:0, tvec:0, exp_pc:32'h204, exp_mis:0};

    clear_in();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_now("rst_async", '{pc:32'h1000, vld:0, mis:0, pred:0});
    @(posedge clk); @(posedge clk); #1;
    check_now("rst_held", '{pc:32'h1000, vld:0, mis:0, pred:0});
    rst_n = 1'b1;
    step("boot_exit", '{pc:32'h1000, vld:1, mis:0, pred:0});
    step("seq_1004",  '{pc:32'h1004, vld:1, mis:0, pred:0});
    step("seq_1008",  '{pc:32'h1008, vld:1, mis:0, pred:0});

    for (int i = 0; i < 16; i++) begin
      stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_addr = vecs[i].raddr;
      trap = vecs[i].trap; trap_vec = vecs[i].tvec;
      step($sformatf("vec%0d", i), '{pc:vecs[i].exp_pc, vld:1, mis:vecs[i].exp_mis, pred:0});
    end
    clear_in();

    // Asynchronous reset mid-run while misaligned is high, then inputs ignored in BOOT.
    redirect = 1; redirect_addr = 32'h3006;
    step("pre_rst_mis", '{pc:32'h204, vld:1, mis:1, pred:0});
    redirect = 1; redirect_addr = 32'h7000; trap = 1; trap_vec = 32'h900;
    #2 rst_n = 1'b0;
    #1 check_now("midrun_rst", '{pc:32'h1000, vld:0, mis:0, pred:0});
    @(posedge clk); #1;
    check_now("midrun_rst_held", '{pc:32'h1000, vld:0, mis:0, pred:0});
    rst_n = 1'b1;
    step("boot_ignores_ctrl", '{pc:32'h1000, vld:1, mis:0, pred:0});
    clear_in();
    step("after_boot", '{pc:32'h1004, vld:1, mis:0, pred:0});

    // BTB training, prediction, aliasing and not-taken clearing.
    redirect = 1; redirect_addr = 32'hF8;
    upd_valid = 1; upd_pc = 32'h100; upd_target = 32'h400; upd_taken = 1;
    step("btb_train", '{pc:32'hF8, vld:1, mis:0, pred:0});
    clear_in();
    step("btb_fc", '{pc:32'hFC, vld:1, mis:0, pred:0});
    step("btb_hit", '{pc:32'h100, vld:1, mis:0, pred:BTB});
    stall = 1;
    step("btb_stall", '{pc:32'h100, vld:1, mis:0, pred:BTB});
    clear_in();
    step("btb_follow", '{pc:(BTB ? 32'h400 : 32'h104), vld:1, mis:0, pred:0});
    redirect = 1; redirect_addr = 32'h140;
    upd_valid = 1; upd_pc = 32'h140; upd_taken = 0; upd_target = 32'h0;
    step("btb_alias", '{pc:32'h140, vld:1, mis:0, pred:0});
    clear_in();
    redirect = 1; redirect_addr = 32'h100;
    step("btb_kept", '{pc:32'h100, vld:1, mis:0, pred:BTB});
    clear_in();
    upd_valid = 1; upd_pc = 32'h100; upd_taken = 0;
    step("btb_old_lookup", '{pc:(BTB ? 32'h400 : 32'h104), vld:1, mis:0, pred:0});
    clear_in();
    redirect = 1; redirect_addr = 32'h100;
    step("btb_cleared", '{pc:32'h100, vld:1, mis:0, pred:0});
    clear_in();
    step("btb_seq", '{pc:32'h104, vld:1, mis:0, pred:0});

    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
